// File: rtl/dcache_port_arbiter_if.sv
// Bundles the requester-side vectors and the single cache-side port that
// dcache_port_arbiter multiplexes between them.
interface dcache_port_arbiter_if #(
  parameter int unsigned NR_PORTS   = 3,
  parameter int unsigned ADDR_WIDTH = 56,
  parameter int unsigned DATA_WIDTH = 64
);
  logic [NR_PORTS-1:0]              req_i;
  logic [NR_PORTS-1:0]              we_i;
  logic [NR_PORTS*ADDR_WIDTH-1:0]   addr_i;
  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i;
  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i;
  logic [NR_PORTS*2-1:0]            size_i;
  logic [NR_PORTS-1:0]              gnt_o;
  logic [NR_PORTS-1:0]              rvalid_o;
  logic [DATA_WIDTH-1:0]            rdata_o;
  logic                             mem_req_o;
  logic                             mem_we_o;
  logic [ADDR_WIDTH-1:0]            mem_addr_o;
  logic [DATA_WIDTH-1:0]            mem_wdata_o;
  logic [DATA_WIDTH/8-1:0]          mem_be_o;
  logic [1:0]                       mem_size_o;
  logic                             mem_gnt_i;
  logic                             mem_rvalid_i;
  logic [DATA_WIDTH-1:0]            mem_rdata_i;
  logic                             busy_o;
  logic                             err_o;

  modport slave (
    input  req_i, we_i, addr_i, wdata_i, be_i, size_i,
    input  mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    output gnt_o, rvalid_o, rdata_o,
    output mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o,
    output busy_o, err_o
  );

  modport master (
    output req_i, we_i, addr_i, wdata_i, be_i, size_i,
    output mem_gnt_i, mem_rvalid_i, mem_rdata_i,
    input  gnt_o, rvalid_o, rdata_o,
    input  mem_req_o, mem_we_o, mem_addr_o, mem_wdata_o, mem_be_o, mem_size_o,
    input  busy_o, err_o
  );
endinterface

// File: rtl/dcache_port_arbiter.sv
// Round-robin arbiter with request locking that shares one D$ port between
// NR_PORTS requesters; read responses return in grant order via an ID FIFO.
module dcache_port_arbiter #(
  parameter int unsigned NR_PORTS        = 3,
  parameter int unsigned ADDR_WIDTH      = 56,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  dcache_port_arbiter_if.slave bus
);
  localparam int unsigned ID_W  = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned PTR_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BE_W  = DATA_WIDTH / 8;
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);
  localparam logic [ID_W-1:0]  LAST_ID  = ID_W'(NR_PORTS - 1);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(MAX_OUTSTANDING - 1);

  function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
    return (id == LAST_ID) ? {ID_W{1'b0}} : id + ID_W'(1);
  endfunction

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
    return (ptr == LAST_PTR) ? {PTR_W{1'b0}} : ptr + PTR_W'(1);
  endfunction

  logic [ID_W-1:0]  rr_ptr_r;
  logic             lock_valid_r;
  logic [ID_W-1:0]  lock_id_r;
  logic [CNT_W-1:0] cnt_r;
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [ID_W-1:0]  id_fifo_r [MAX_OUTSTANDING];
  logic             err_r;

  logic [NR_PORTS-1:0] elig_s;
  logic [ID_W-1:0]     sel_s;
  logic [ID_W-1:0]     cand_s;
  logic                found_s;
  logic                hit_s;
  logic                mem_req_s;
  logic                grant_s;
  logic                push_s;
  logic                pop_s;
  logic                spurious_s;
  logic [ID_W-1:0]     head_s;

  // Reads need a free FIFO slot as seen by the registered count; writes never do.
  assign elig_s     = bus.req_i & (bus.we_i | {NR_PORTS{cnt_r < MAX_CNT}});
  assign mem_req_s  = found_s & elig_s[sel_s];
  assign grant_s    = mem_req_s & bus.mem_gnt_i;
  assign push_s     = grant_s & ~bus.we_i[sel_s];
  assign pop_s      = bus.mem_rvalid_i & (cnt_r != {CNT_W{1'b0}});
  assign spurious_s = bus.mem_rvalid_i & (cnt_r == {CNT_W{1'b0}});
  assign head_s     = id_fifo_r[rd_ptr_r];

  // Port selection: a held lock wins, else first eligible port from rr_ptr onward.
  always_comb begin
    sel_s   = rr_ptr_r;
    cand_s  = rr_ptr_r;
    found_s = 1'b0;
    hit_s   = 1'b0;
    if (lock_valid_r) begin
      sel_s   = lock_id_r;
      found_s = 1'b1;
    end else begin
      for (int i = 0; i < int'(NR_PORTS); i++) begin
        hit_s   = ~found_s & elig_s[cand_s];
        sel_s   = hit_s ? cand_s : sel_s;
        found_s = found_s | hit_s;
        cand_s  = next_id(cand_s);
      end
    end
  end

  // Output forwarding, held at zero while reset is asserted.
  always_comb begin
    bus.mem_req_o   = 1'b0;
    bus.gnt_o       = {NR_PORTS{1'b0}};
    bus.rvalid_o    = {NR_PORTS{1'b0}};
    bus.rdata_o     = {DATA_WIDTH{1'b0}};
    bus.mem_we_o    = 1'b0;
    bus.mem_addr_o  = {ADDR_WIDTH{1'b0}};
    bus.mem_wdata_o = {DATA_WIDTH{1'b0}};
    bus.mem_be_o    = {BE_W{1'b0}};
    bus.mem_size_o  = 2'b00;
    bus.busy_o      = 1'b0;
    bus.err_o       = 1'b0;
    if (!rst_i) begin
      bus.mem_req_o         = mem_req_s;
      bus.gnt_o[sel_s]      = grant_s;
      bus.rvalid_o[head_s]  = pop_s;
      bus.rdata_o           = bus.mem_rdata_i;
      bus.mem_we_o          = bus.we_i[sel_s];
      bus.mem_addr_o        = bus.addr_i[int'(sel_s)*ADDR_WIDTH +: ADDR_WIDTH];
      bus.mem_wdata_o       = bus.wdata_i[int'(sel_s)*DATA_WIDTH +: DATA_WIDTH];
      bus.mem_be_o          = bus.be_i[int'(sel_s)*BE_W +: BE_W];
      bus.mem_size_o        = bus.size_i[int'(sel_s)*2 +: 2];
      bus.busy_o            = (cnt_r != {CNT_W{1'b0}});
      bus.err_o             = err_r;
    end else begin
      bus.mem_req_o = 1'b0;
    end
  end

  // Arbitration state; a stalled request locks, and a dropped request unlocks.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rr_ptr_r     <= {ID_W{1'b0}};
      lock_valid_r <= 1'b0;
      lock_id_r    <= {ID_W{1'b0}};
    end else begin
      lock_valid_r <= mem_req_s & ~bus.mem_gnt_i;
      lock_id_r    <= mem_req_s ? sel_s : lock_id_r;
      rr_ptr_r     <= grant_s ? next_id(sel_s) : rr_ptr_r;
    end
  end

  // Outstanding-read bookkeeping and the sticky spurious-response flag.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_r    <= {CNT_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      rd_ptr_r <= {PTR_W{1'b0}};
      err_r    <= 1'b0;
    end else begin
      cnt_r    <= cnt_r + CNT_W'(push_s) - CNT_W'(pop_s);
      wr_ptr_r <= push_s ? next_ptr(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r <= pop_s ? next_ptr(rd_ptr_r) : rd_ptr_r;
      err_r    <= err_r | spurious_s;
    end
  end

  // ID storage for granted reads, oldest entry at rd_ptr_r.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < int'(MAX_OUTSTANDING); i++) begin
        id_fifo_r[i] <= {ID_W{1'b0}};
      end
    end else if (push_s) begin
      id_fifo_r[wr_ptr_r] <= sel_s;
    end else begin
      id_fifo_r[wr_ptr_r] <= id_fifo_r[wr_ptr_r];
    end
  end
endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed and randomized bench for dcache_port_arbiter, checked cycle by cycle
// against a queue-based reference model of the arbitration and response rules.
module tb_dcache_port_arbiter;
  localparam int N    = 3;
  localparam int AW   = 56;
  localparam int DW   = 64;
  localparam int MAXO = 2;
  localparam int BEW  = DW / 8;

  logic clk_s = 1'b0;
  logic rst_s = 1'b1;

  dcache_port_arbiter_if #(.NR_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  dcache_port_arbiter #(
    .NR_PORTS(N), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk_i (clk_s),
    .rst_i (rst_s),
    .bus   (bus)
  );

  always #5 clk_s = ~clk_s;

  int n_vec = 0;
  int n_err = 0;

  // reference model state
  int rr_m     = 0;
  bit lock_m   = 1'b0;
  int lockp_m  = 0;
  int q_m[$];
  bit err_m    = 1'b0;
  int sel_m    = 0;
  bit mreq_m   = 1'b0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic bit elig_m(input int k);
    return bus.req_i[k] && (bus.we_i[k] || (q_m.size() < MAXO));
  endfunction

  task automatic model_reset();
    rr_m = 0; lock_m = 1'b0; lockp_m = 0; err_m = 1'b0;
    q_m.delete();
  endtask

  task automatic model_eval();
    mreq_m = 1'b0;
    sel_m  = rr_m;
    if (lock_m) begin
      sel_m  = lockp_m;
      mreq_m = elig_m(lockp_m);
    end else begin
      for (int i = 0; i < N; i++) begin
        int k;
        k = (rr_m + i) % N;
        if (!mreq_m && elig_m(k)) begin
          sel_m  = k;
          mreq_m = 1'b1;
        end
      end
    end
  endtask

  task automatic check_all();
    logic [63:0] eg;
    logic [63:0] ev;
    eg = 64'd0;
    ev = 64'd0;
    if (mreq_m && bus.mem_gnt_i) eg = 64'd1 << sel_m;
    if (bus.mem_rvalid_i && q_m.size() > 0) ev = 64'd1 << q_m[0];
    chk("mem_req", bus.mem_req_o, mreq_m);
    chk("gnt", bus.gnt_o, eg);
    chk("rvalid", bus.rvalid_o, ev);
    if (ev != 64'd0) chk("rdata", bus.rdata_o, bus.mem_rdata_i);
    if (mreq_m) begin
      chk("mem_addr", bus.mem_addr_o, bus.addr_i[sel_m*AW +: AW]);
      chk("mem_we", bus.mem_we_o, bus.we_i[sel_m]);
      chk("mem_wdata", bus.mem_wdata_o, bus.wdata_i[sel_m*DW +: DW]);
      chk("mem_be", bus.mem_be_o, bus.be_i[sel_m*BEW +: BEW]);
      chk("mem_size", bus.mem_size_o, bus.size_i[sel_m*2 +: 2]);
    end
    chk("busy", bus.busy_o, q_m.size() != 0);
    chk("err", bus.err_o, err_m);
  endtask

  task automatic model_update();
    bit granted;
    granted = mreq_m && bus.mem_gnt_i;
    if (bus.mem_rvalid_i) begin
      if (q_m.size() > 0) void'(q_m.pop_front());
      else err_m = 1'b1;
    end
    if (granted) begin
      if (!bus.we_i[sel_m]) q_m.push_back(sel_m);
      rr_m = (sel_m + 1) % N;
    end
    lock_m = mreq_m && !bus.mem_gnt_i;
    if (mreq_m) lockp_m = sel_m;
  endtask

  // one clock: check at the falling edge, advance the model after the rising edge
  task automatic step();
    @(negedge clk_s);
    model_eval();
    check_all();
    @(posedge clk_s);
    model_update();
    #1;
  endtask

  task automatic set_port(input int k, input bit r, input bit w,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
    bus.req_i[k]            = r;
    bus.we_i[k]             = w;
    bus.addr_i[k*AW +: AW]  = a;
    bus.wdata_i[k*DW +: DW] = d;
    bus.be_i[k*BEW +: BEW]  = 8'hFF;
    bus.size_i[k*2 +: 2]    = 2'd3;
  endtask

  task automatic idle();
    bus.req_i        = 3'b000;
    bus.we_i         = 3'b000;
    bus.mem_gnt_i    = 1'b0;
    bus.mem_rvalid_i = 1'b0;
  endtask

  task automatic rand_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      for (int k = 0; k < N; k++) begin
        set_port(k, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                 {$urandom(), $urandom()}, {$urandom(), $urandom()});
        bus.be_i[k*BEW +: BEW] = 8'($urandom());
        bus.size_i[k*2 +: 2]   = 2'($urandom());
      end
      bus.mem_gnt_i   = $urandom_range(0, 2) != 0;
      bus.mem_rdata_i = {$urandom(), $urandom()};
      if (q_m.size() > 0) bus.mem_rvalid_i = $urandom_range(0, 1) == 1;
      else bus.mem_rvalid_i = $urandom_range(0, 15) == 0;
      step();
    end
  endtask

  initial begin
    bus.addr_i = '0; bus.wdata_i = '0; bus.be_i = '0; bus.size_i = '0;
    bus.mem_rdata_i = 64'hDEAD;
    idle();
    // reset: everything quiet even with live requests and a response
    set_port(0, 1'b1, 1'b1, 56'h123, 64'h55);
    bus.mem_gnt_i = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    #2;
    chk("rst_mem_req", bus.mem_req_o, 1'b0);
    chk("rst_gnt", bus.gnt_o, 3'b000);
    chk("rst_rvalid", bus.rvalid_o, 3'b000);
    chk("rst_rdata", bus.rdata_o, 64'h0);
    chk("rst_addr", bus.mem_addr_o, 56'h0);
    chk("rst_busy", bus.busy_o, 1'b0);
    chk("rst_err", bus.err_o, 1'b0);
    idle();
    @(posedge clk_s); #1;
    rst_s = 1'b0;
    model_reset();

    // single port read and its response
    set_port(0, 1'b1, 1'b0, 56'h80, 64'h0);
    bus.mem_gnt_i = 1'b1;
    #1 chk("sp_gnt", bus.gnt_o, 3'b001);
    chk("sp_addr", bus.mem_addr_o, 56'h80);
    step();
    chk("sp_busy", bus.busy_o, 1'b1);
    idle();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'hDEAD;
    #1 chk("sp_rvalid", bus.rvalid_o, 3'b001);
    chk("sp_rdata", bus.rdata_o, 64'hDEAD);
    step();
    chk("sp_idle", bus.busy_o, 1'b0);

    // round robin: park pointer at 0, then all ports write continuously
    idle();
    set_port(2, 1'b1, 1'b1, 56'h200, 64'h2);
    bus.mem_gnt_i = 1'b1;
    step();
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b1, 56'(k * 16), 64'(k));
    for (int i = 0; i < 6; i++) begin
      #1 chk("rr_order", bus.gnt_o, 64'd1 << (i % 3));
      step();
    end

    // lock: port1 stalls for three cycles, then port1 and port2 in turn
    idle();
    set_port(0, 1'b1, 1'b1, 56'h0, 64'h0);
    bus.mem_gnt_i = 1'b1;
    step();
    idle();
    set_port(1, 1'b1, 1'b1, 56'hA1A1, 64'h11);
    set_port(2, 1'b1, 1'b1, 56'hA2A2, 64'h22);
    for (int i = 0; i < 3; i++) begin
      if (i == 1) set_port(0, 1'b1, 1'b1, 56'hA0A0, 64'h0);
      #1 chk("lock_addr", bus.mem_addr_o, 56'hA1A1);
      chk("lock_nogrant", bus.gnt_o, 3'b000);
      step();
    end
    bus.req_i[0] = 1'b0;
    bus.mem_gnt_i = 1'b1;
    #1 chk("lock_grant1", bus.gnt_o, 3'b010);
    step();
    #1 chk("lock_grant2", bus.gnt_o, 3'b100);
    step();

    // FIFO full: reads from port0 and port2 fill it; port1 read waits, write passes
    idle();
    set_port(0, 1'b1, 1'b0, 56'h300, 64'h0);
    bus.mem_gnt_i = 1'b1;
    #1 chk("full_rd0", bus.gnt_o, 3'b001);
    step();
    idle();
    set_port(2, 1'b1, 1'b0, 56'h320, 64'h0);
    bus.mem_gnt_i = 1'b1;
    #1 chk("full_rd2", bus.gnt_o, 3'b100);
    step();
    idle();
    set_port(1, 1'b1, 1'b0, 56'h310, 64'h0);
    bus.mem_gnt_i = 1'b1;
    #1 chk("full_noreq", bus.mem_req_o, 1'b0);
    chk("full_nogrant", bus.gnt_o, 3'b000);
    step();
    set_port(1, 1'b1, 1'b1, 56'h310, 64'h77);
    #1 chk("full_write", bus.gnt_o, 3'b010);
    step();
    idle();
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'h1111;
    #1 chk("full_resp0", bus.rvalid_o, 3'b001);
    step();
    bus.mem_rdata_i = 64'h2222;
    #1 chk("full_resp2", bus.rvalid_o, 3'b100);
    chk("full_rdata", bus.rdata_o, 64'h2222);
    step();
    idle();
    chk("full_drained", bus.busy_o, 1'b0);

    // simultaneous push and pop
    set_port(0, 1'b1, 1'b0, 56'h400, 64'h0);
    bus.mem_gnt_i = 1'b1;
    #1 chk("pp_first", bus.gnt_o, 3'b001);
    step();
    idle();
    set_port(1, 1'b1, 1'b0, 56'h410, 64'h0);
    bus.mem_gnt_i    = 1'b1;
    bus.mem_rvalid_i = 1'b1;
    bus.mem_rdata_i  = 64'h3333;
    #1 chk("pp_rvalid", bus.rvalid_o, 3'b001);
    chk("pp_gnt", bus.gnt_o, 3'b010);
    step();
    idle();
    chk("pp_busy", bus.busy_o, 1'b1);
    bus.mem_rvalid_i = 1'b1;
    #1 chk("pp_resp1", bus.rvalid_o, 3'b010);
    step();
    idle();
    chk("pp_idle", bus.busy_o, 1'b0);

    // spurious response sets a sticky error
    bus.mem_rvalid_i = 1'b1;
    #1 chk("spur_rvalid", bus.rvalid_o, 3'b000);
    step();
    idle();
    chk("spur_err", bus.err_o, 1'b1);
    step();
    step();
    chk("spur_sticky", bus.err_o, 1'b1);

    rand_cycles(800);

    // drain, fill two reads, then reset in the middle of a cycle
    idle();
    step();
    for (int i = 0; i < 4 && q_m.size() > 0; i++) begin
      bus.mem_rvalid_i = 1'b1;
      step();
    end
    idle();
    chk("drain_busy", bus.busy_o, 1'b0);
    set_port(0, 1'b1, 1'b0, 56'h500, 64'h0);
    bus.mem_gnt_i = 1'b1;
    step();
    idle();
    set_port(1, 1'b1, 1'b0, 56'h510, 64'h0);
    bus.mem_gnt_i = 1'b1;
    step();
    idle();
    chk("mid_full", bus.busy_o, 1'b1);
    set_port(1, 1'b1, 1'b1, 56'h520, 64'h0);
    bus.mem_gnt_i = 1'b1;
    #2 rst_s = 1'b1;
    #1 chk("mid_busy", bus.busy_o, 1'b0);
    chk("mid_err", bus.err_o, 1'b0);
    chk("mid_mem_req", bus.mem_req_o, 1'b0);
    chk("mid_gnt", bus.gnt_o, 3'b000);
    model_reset();
    @(posedge clk_s); #1;
    idle();
    rst_s = 1'b0;
    for (int k = 0; k < N; k++) set_port(k, 1'b1, 1'b1, 56'(k + 1), 64'(k));
    bus.mem_gnt_i = 1'b1;
    #1 chk("post_rst_rr", bus.gnt_o, 3'b001);
    step();

    rand_cycles(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
